simmem_raddr_arbiter: RTL and testbench
=======================================

Name: simmem_raddr_arbiter

Overview:
- Shares the single read-address channel of the simulated memory controller between NumReq requesters, using round-robin arbitration.
- The requester index is prepended to the AXI ID on the way down, so returning read data can be routed and accounted per requester.
- Keeps a per-requester outstanding-burst counter and stops granting a requester once it reaches MaxOutstanding.
- Sits directly upstream of the controller's raddr input; the ID-extended output feeds the response-bank reservation logic.

Parameters:
- NumReq, 4, number of requesters (>=2); ReqIdxW = $clog2(NumReq).
- PayloadW, 64, width of the packed raddr fields excluding ID.
- LocalIdW, 4, requester-side ID width; output ID width is LocalIdW+ReqIdxW.
- MaxOutstanding, 8, maximum accepted-but-not-completed bursts per requester; CntW = $clog2(MaxOutstanding+1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  NumReq  per-requester address valid.
- req_ready_o  out  NumReq  per-requester address ready; at most one bit high per cycle.
- req_payload_i  in  NumReq*PayloadW  packed payloads; requester k occupies slice [k*PayloadW +: PayloadW].
- req_id_i  in  NumReq*LocalIdW  packed local IDs.
- raddr_valid_o  out  1  downstream valid.
- raddr_ready_i  in  1  downstream ready.
- raddr_payload_o  out  PayloadW  registered payload.
- raddr_id_o  out  LocalIdW+ReqIdxW  {requester index, local ID}.
- done_valid_i  in  1  pulse: last read beat of a burst handshaked at the controller output.
- done_id_i  in  LocalIdW+ReqIdxW  ID of the completed burst; upper ReqIdxW bits select the requester.
- outstanding_o  out  NumReq*CntW  per-requester outstanding counts.
- err_o  out  1  sticky error flag.

Behaviour:
- Reset (async, rst_i=1): raddr_valid_o=0, raddr_payload_o=0, raddr_id_o=0, all counters=0, err_o=0, state=EMPTY, rr pointer=NumReq-1 (requester 0 has first priority). req_ready_o is 0 while rst_i=1. Reset mid-burst drops the held request and all counts.
- FSM, 2 states. EMPTY: output register invalid. FULL: output register holds a request, raddr_valid_o=1.
- Eligibility: requester k is eligible when req_valid_i[k]=1 and count[k]<MaxOutstanding.
- Accept window: state=EMPTY, or state=FULL with raddr_ready_i=1 (drain and refill in the same cycle; sustains 1 request/cycle).
- Accept: in an accept window with at least one eligible requester, grant the first eligible index searching ptr+1, ptr+2, ... modulo NumReq.
  - Combinationally raise req_ready_o[g].
  - Register payload and {g, req_id_i[g]} at the clock edge; next state FULL; ptr<=g; count[g]++.
- No eligible requester:
  - FULL with raddr_ready_i=1 goes to EMPTY.
  - FULL with raddr_ready_i=0 holds; payload and ID stay stable while raddr_valid_o=1 (AXI rule).
- Latency: request accepted in cycle N is presented on raddr_* in cycle N+1.
- Counter decrement: done_valid_i=1 decrements count[done_id_i[top ReqIdxW bits]].
  - Increment and decrement on the same requester in the same cycle leave the count unchanged.
  - Decrement at 0: count stays 0 and err_o is set.
  - A done index >= NumReq (non-power-of-2 NumReq): ignored and err_o is set.
  - err_o clears only on reset.
- A requester at MaxOutstanding that completes a burst becomes eligible in the cycle after done_valid_i.
- req_ready_o never depends on req_valid_i of the granted requester beyond eligibility; it is never asserted without the corresponding valid.

Test Plan:
- Single requester: req 2 valid with payload 0xABCD and id 3, raddr_ready_i=1 -> req_ready_o=0b0100 in cycle 0; cycle 1 raddr_valid_o=1, payload 0xABCD, raddr_id_o={2,3}; outstanding[2]=1.
- Fairness: all 4 valid continuously, raddr_ready_i=1 -> grant order 0,1,2,3,0,1 on consecutive cycles, one accept per cycle.
- Backpressure: raddr_ready_i=0 for 5 cycles while FULL -> raddr_* stable, all req_ready_o=0; ready rises -> drain and refill in the same cycle.
- Outstanding limit: MaxOutstanding=2, req 1 issues 2 bursts with no done -> third request stalls; done_valid_i with id {1,x} -> accepted the next cycle.
- Simultaneous increment and decrement: accept on req 0 and done for req 0 in the same cycle with count=1 -> count stays 1.
- Errors and reset: done for req 3 with count=0 -> err_o=1, count stays 0. Assert rst_i while FULL -> raddr_valid_o=0 immediately (async), counts=0, err_o=0.

Source files
------------

// File: rtl/simmem_raddr_arbiter.sv
// ---------------------------------------------------------------------------
// simmem_raddr_arbiter
//
// Round-robin arbiter that shares the read-address channel of the simulated
// memory controller between NumReq requesters. The winner's index is
// prepended to its local AXI ID so that returning read data can be routed
// and accounted per requester. Each requester has an outstanding-burst
// counter. The counter goes up when a request is accepted and goes down when
// the controller reports that the last beat of a burst has been handshaked.
// A requester whose counter has reached MaxOutstanding is not granted.
//
// Ports:
//   clk_i            clock
//   rst_i            asynchronous, active-high reset
//   req_valid_i      per-requester address valid                 [NumReq]
//   req_ready_o      per-requester address ready, one-hot or 0   [NumReq]
//   req_payload_i    packed payloads, requester k at [k*PayloadW +: PayloadW]
//   req_id_i         packed local IDs, requester k at [k*LocalIdW +: LocalIdW]
//   raddr_valid_o    downstream valid (output register full)
//   raddr_ready_i    downstream ready
//   raddr_payload_o  registered payload
//   raddr_id_o       registered {requester index, local ID}
//   done_valid_i     pulse: a burst completed at the controller output
//   done_id_i        ID of the completed burst, top ReqIdxW bits = requester
//   outstanding_o    packed per-requester outstanding counts     [NumReq*CntW]
//   err_o            sticky error: done underflow or done index out of range
// ---------------------------------------------------------------------------
module simmem_raddr_arbiter #(
  parameter int NumReq         = 4,
  parameter int PayloadW       = 64,
  parameter int LocalIdW       = 4,
  parameter int MaxOutstanding = 8,
  localparam int ReqIdxW       = $clog2(NumReq),
  localparam int OutIdW        = LocalIdW + ReqIdxW,
  localparam int CntW          = $clog2(MaxOutstanding + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumReq-1:0]            req_valid_i,
  output logic [NumReq-1:0]            req_ready_o,
  input  logic [NumReq*PayloadW-1:0]   req_payload_i,
  input  logic [NumReq*LocalIdW-1:0]   req_id_i,
  output logic                         raddr_valid_o,
  input  logic                         raddr_ready_i,
  output logic [PayloadW-1:0]          raddr_payload_o,
  output logic [OutIdW-1:0]            raddr_id_o,
  input  logic                         done_valid_i,
  input  logic [OutIdW-1:0]            done_id_i,
  output logic [NumReq*CntW-1:0]       outstanding_o,
  output logic                         err_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam logic [CntW-1:0]    MaxCnt     = CntW'(MaxOutstanding);
  localparam logic [ReqIdxW:0]   NumReqExt  = (ReqIdxW + 1)'(NumReq);
  localparam logic [ReqIdxW-1:0] PtrRstVal  = ReqIdxW'(NumReq - 1);

  // Register state and next-state values
  state_e                state_q, state_d;
  logic [ReqIdxW-1:0]    ptr_q, ptr_d;
  logic [PayloadW-1:0]   payload_q, payload_d;
  logic [OutIdW-1:0]     id_q, id_d;
  logic [CntW-1:0]       cnt_q [NumReq];
  logic [CntW-1:0]       cnt_d [NumReq];
  logic                  err_q, err_d;

  // Arbitration signals
  logic [NumReq-1:0]     eligible;
  logic                  grant_valid;
  logic [ReqIdxW-1:0]    grant_idx;
  logic                  accept_win;
  logic                  accept;

  // Completion decode
  logic [ReqIdxW-1:0]    done_idx;
  logic                  done_idx_ok;
  logic [NumReq-1:0]     inc_vec;
  logic [NumReq-1:0]     dec_vec;
  logic                  done_local_unused;

  // Candidate index at offset 'off' (1..NumReq) after the pointer, modulo NumReq.
  function automatic logic [ReqIdxW-1:0] rr_idx(input logic [ReqIdxW-1:0] p,
                                                input int off);
    int s;
    s = int'(p) + off;
    if (s >= NumReq) s = s - NumReq;
    return ReqIdxW'(s);
  endfunction

  // -------------------------------------------------------------------------
  // Eligibility and round-robin search
  // -------------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < NumReq; k++) begin
      eligible[k] = req_valid_i[k] && (cnt_q[k] < MaxCnt);
    end
  end

  // NOTE: every output of a combinational block gets a default before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    // The search starts just after the last winner, so the last winner
    // has the lowest priority.
    for (int i = 1; i <= NumReq; i++) begin
      if (!grant_valid && eligible[rr_idx(ptr_q, i)]) begin
        grant_valid = 1'b1;
        grant_idx   = rr_idx(ptr_q, i);
      end
    end
  end

  // The output register can take a new request when it is empty. It can
  // also take one when it is draining this cycle, which sustains one
  // request per cycle.
  assign accept_win = (state_q == EMPTY) || raddr_ready_i;
  assign accept     = accept_win && grant_valid && !rst_i;

  always_comb begin
    req_ready_o = '0;
    if (accept) req_ready_o[grant_idx] = 1'b1;
  end

  // -------------------------------------------------------------------------
  // Output-register FSM: next state and data
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    payload_d = payload_q;
    id_d      = id_q;
    if (accept) begin
      state_d   = FULL;
      ptr_d     = grant_idx;
      payload_d = req_payload_i[grant_idx*PayloadW +: PayloadW];
      id_d      = {grant_idx, req_id_i[grant_idx*LocalIdW +: LocalIdW]};
    end else if (state_q == FULL && raddr_ready_i) begin
      state_d = EMPTY;
    end
    // FULL without ready keeps payload and ID stable while valid is high.
  end

  // -------------------------------------------------------------------------
  // Outstanding counters and error flag
  // -------------------------------------------------------------------------
  assign done_idx          = done_id_i[OutIdW-1 -: ReqIdxW];
  // The index can only be out of range when NumReq is not a power of two.
  assign done_idx_ok       = {1'b0, done_idx} < NumReqExt;
  // The local ID bits of a completion are not needed for accounting.
  assign done_local_unused = ^done_id_i[LocalIdW-1:0];

  always_comb begin
    for (int k = 0; k < NumReq; k++) begin
      inc_vec[k] = accept && (grant_idx == ReqIdxW'(k));
      dec_vec[k] = done_valid_i && done_idx_ok && (done_idx == ReqIdxW'(k));
    end
  end

  always_comb begin
    err_d = err_q;
    if (done_valid_i && !done_idx_ok) err_d = 1'b1;
    for (int k = 0; k < NumReq; k++) begin
      cnt_d[k] = cnt_q[k];
      if (inc_vec[k] && !dec_vec[k]) begin
        cnt_d[k] = cnt_q[k] + CntW'(1);
      end else if (dec_vec[k] && !inc_vec[k]) begin
        if (cnt_q[k] == '0) err_d = 1'b1;      // underflow: count holds at 0
        else                cnt_d[k] = cnt_q[k] - CntW'(1);
      end
      // An increment and a decrement in the same cycle cancel each other.
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= EMPTY;
      ptr_q     <= PtrRstVal;
      payload_q <= '0;
      id_q      <= '0;
      err_q     <= 1'b0;
      // NOTE: the counter array is a handful of flops, not a RAM. Resetting
      // it is cheap and required, because a reset drops all in-flight bursts.
      for (int k = 0; k < NumReq; k++) cnt_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      payload_q <= payload_d;
      id_q      <= id_d;
      err_q     <= err_d;
      for (int k = 0; k < NumReq; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign raddr_valid_o   = (state_q == FULL);
  assign raddr_payload_o = payload_q;
  assign raddr_id_o      = id_q;
  assign err_o           = err_q;

  always_comb begin
    for (int k = 0; k < NumReq; k++) begin
      outstanding_o[k*CntW +: CntW] = cnt_q[k];
    end
  end

endmodule

// File: tb/tb_simmem_raddr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_simmem_raddr_arbiter
//
// Directed testbench for simmem_raddr_arbiter, built with NumReq=4,
// PayloadW=16, LocalIdW=4 and MaxOutstanding=2. Inputs are driven on the
// falling edge. Combinational outputs are sampled 1 ns later. Registered
// outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_simmem_raddr_arbiter;

  localparam int NumReq   = 4;
  localparam int PayloadW = 16;
  localparam int LocalIdW = 4;
  localparam int MaxOut   = 2;
  localparam int ReqIdxW  = 2;
  localparam int OutIdW   = 6;
  localparam int CntW     = 2;

  logic                       clk_i = 1'b0;
  logic                       rst_i;
  logic [NumReq-1:0]          req_valid_i;
  logic [NumReq-1:0]          req_ready_o;
  logic [NumReq*PayloadW-1:0] req_payload_i;
  logic [NumReq*LocalIdW-1:0] req_id_i;
  logic                       raddr_valid_o;
  logic                       raddr_ready_i;
  logic [PayloadW-1:0]        raddr_payload_o;
  logic [OutIdW-1:0]          raddr_id_o;
  logic                       done_valid_i;
  logic [OutIdW-1:0]          done_id_i;
  logic [NumReq*CntW-1:0]     outstanding_o;
  logic                       err_o;

  int n_checks = 0;
  int n_pass   = 0;

  simmem_raddr_arbiter #(
    .NumReq(NumReq), .PayloadW(PayloadW), .LocalIdW(LocalIdW),
    .MaxOutstanding(MaxOut)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_payload_i(req_payload_i), .req_id_i(req_id_i),
    .raddr_valid_o(raddr_valid_o), .raddr_ready_i(raddr_ready_i),
    .raddr_payload_o(raddr_payload_o), .raddr_id_o(raddr_id_o),
    .done_valid_i(done_valid_i), .done_id_i(done_id_i),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic set_req(input int k, input logic [PayloadW-1:0] p,
                         input logic [LocalIdW-1:0] id);
    req_payload_i[k*PayloadW +: PayloadW] = p;
    req_id_i[k*LocalIdW +: LocalIdW]      = id;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    req_valid_i = '0; raddr_ready_i = 1'b1;
    done_valid_i = 1'b0; done_id_i = '0;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Advance to the sampling point just after the next rising edge.
  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  initial begin
    rst_i = 1'b1;
    req_valid_i = '0; req_payload_i = '0; req_id_i = '0;
    raddr_ready_i = 1'b0; done_valid_i = 1'b0; done_id_i = '0;
    for (int k = 0; k < NumReq; k++) set_req(k, PayloadW'(16'h1000 * (k + 1)), LocalIdW'(k + 8));

    // ---- reset state ----
    req_valid_i = 4'b1111;
    @(negedge clk_i); #1;
    check("rst_ready",   req_ready_o,   4'b0000);
    check("rst_valid",   raddr_valid_o, 1'b0);
    check("rst_payload", raddr_payload_o, 16'h0);
    check("rst_id",      raddr_id_o,    6'h0);
    check("rst_cnt",     outstanding_o, 8'h00);
    check("rst_err",     err_o,         1'b0);
    do_reset();

    // ---- single requester ----
    @(negedge clk_i);
    set_req(2, 16'hABCD, 4'd3);
    req_valid_i = 4'b0100; raddr_ready_i = 1'b1;
    #1 check("single_ready", req_ready_o, 4'b0100);
    tick();
    check("single_valid",   raddr_valid_o,   1'b1);
    check("single_payload", raddr_payload_o, 16'hABCD);
    check("single_id",      raddr_id_o,      6'h23);
    check("single_cnt",     outstanding_o,   8'h10);
    @(negedge clk_i); req_valid_i = '0;
    tick();
    check("single_drain", raddr_valid_o, 1'b0);

    // ---- fairness ----
    do_reset();
    for (int k = 0; k < NumReq; k++) set_req(k, PayloadW'(16'h1000 * (k + 1)), LocalIdW'(k + 8));
    @(negedge clk_i);
    req_valid_i = 4'b1111; raddr_ready_i = 1'b1;
    begin
      int order [6] = '{0, 1, 2, 3, 0, 1};
      for (int i = 0; i < 6; i++) begin
        #1 check($sformatf("rr_grant%0d", i), req_ready_o, 4'b0001 << order[i]);
        tick();
        check($sformatf("rr_id%0d", i), raddr_id_o, {2'(order[i]), 4'(order[i] + 8)});
        @(negedge clk_i);
      end
    end
    check("rr_cnt", outstanding_o, 8'h5A);
    // Requesters 0 and 1 are at the limit, so the pointer moves on to 2.
    #1 check("rr_limit_skip", req_ready_o, 4'b0100);
    tick();
    @(negedge clk_i); req_valid_i = '0;

    // ---- backpressure ----
    do_reset();
    @(negedge clk_i);
    set_req(0, 16'h1111, 4'd5); set_req(1, 16'h2222, 4'd6);
    req_valid_i = 4'b0001; raddr_ready_i = 1'b0;
    #1 check("bp_accept_empty", req_ready_o, 4'b0001);
    tick();
    @(negedge clk_i);
    req_valid_i = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("bp_ready%0d", i),   req_ready_o,     4'b0000);
      check($sformatf("bp_payload%0d", i), raddr_payload_o, 16'h1111);
      check($sformatf("bp_id%0d", i),      raddr_id_o,      6'h05);
      check($sformatf("bp_valid%0d", i),   raddr_valid_o,   1'b1);
      @(negedge clk_i);
    end
    raddr_ready_i = 1'b1;
    #1 check("bp_refill_ready", req_ready_o, 4'b0010);
    tick();
    check("bp_refill_payload", raddr_payload_o, 16'h2222);
    check("bp_refill_id",      raddr_id_o,      6'h16);
    check("bp_refill_valid",   raddr_valid_o,   1'b1);
    @(negedge clk_i); req_valid_i = '0;
    tick();
    check("bp_empty", raddr_valid_o, 1'b0);

    // ---- outstanding limit ----
    do_reset();
    @(negedge clk_i);
    req_valid_i = 4'b0010; raddr_ready_i = 1'b1;
    #1 check("lim_first", req_ready_o, 4'b0010);
    tick(); @(negedge clk_i);
    #1 check("lim_second", req_ready_o, 4'b0010);
    tick(); @(negedge clk_i);
    #1 check("lim_stall", req_ready_o, 4'b0000);
    check("lim_cnt_full", outstanding_o, 8'h08);
    tick(); @(negedge clk_i);
    done_valid_i = 1'b1; done_id_i = 6'h17;
    #1 check("lim_done_cycle", req_ready_o, 4'b0000);
    tick();
    check("lim_cnt_dec", outstanding_o, 8'h04);
    @(negedge clk_i); done_valid_i = 1'b0;
    #1 check("lim_resume", req_ready_o, 4'b0010);
    tick();
    check("lim_cnt_again", outstanding_o, 8'h08);
    @(negedge clk_i); req_valid_i = '0;

    // ---- simultaneous increment and decrement ----
    do_reset();
    @(negedge clk_i);
    req_valid_i = 4'b0001;
    tick();
    check("sim_cnt1", outstanding_o, 8'h01);
    @(negedge clk_i);
    done_valid_i = 1'b1; done_id_i = 6'h02;
    #1 check("sim_ready", req_ready_o, 4'b0001);
    tick();
    check("sim_cnt_same", outstanding_o, 8'h01);
    check("sim_no_err",   err_o,         1'b0);

    // ---- underflow error and async reset ----
    @(negedge clk_i);
    req_valid_i = '0;
    done_valid_i = 1'b1; done_id_i = 6'h30;
    tick();
    check("err_set", err_o,         1'b1);
    check("err_cnt", outstanding_o, 8'h01);
    @(negedge clk_i);
    done_valid_i = 1'b0;
    req_valid_i = 4'b0100; raddr_ready_i = 1'b0;
    tick();
    check("err_sticky", err_o,         1'b1);
    check("pre_rst_full", raddr_valid_o, 1'b1);
    #2 rst_i = 1'b1;
    #1;
    check("arst_valid", raddr_valid_o, 1'b0);
    check("arst_cnt",   outstanding_o, 8'h00);
    check("arst_err",   err_o,         1'b0);
    check("arst_ready", req_ready_o,   4'b0000);
    @(negedge clk_i); rst_i = 1'b0; req_valid_i = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
